// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types and defaults for the data-memory bus arbiter.
// The optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

    localparam int ADDR_W            = 32;
    localparam int DATA_W            = 32;
    localparam int DEFAULT_MAX_WAIT  = 8;
    localparam int DEFAULT_BURST_LEN = 4;

    typedef enum logic {
        CPU_OWN = 1'b0,
        EXT_OWN = 1'b1
    } arbState_t;

endpackage

// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the external master and DataMemory.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dmem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ext_req;
    logic              ext_wr;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_wr, ext_addr, ext_wdata,
        output ext_gnt, ext_rdata, ext_rvalid,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_wr, ext_addr, ext_wdata,
        input  ext_gnt, ext_rdata, ext_rvalid,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_bus_arbiter_perf_cnt.sv
// 32-bit event counter with synchronous clear (clear beats enable), wraps at 2^32.
// Only instantiated when DMEM_ARB_PERF_EN is defined.
module dmem_arb_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// Arbitrates DataMemory between the CPU MEM stage (default owner) and an external master.
// Define DMEM_ARB_PERF_EN to add stall / external-beat performance counters.
module dmem_bus_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT  = DEFAULT_MAX_WAIT,
    parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DMEM_ARB_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_ext_cnt,
`endif
    dmem_bus_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    arbState_t   state;
    arbState_t   nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic [BEAT_W-1:0] beatCnt;
    logic [BEAT_W-1:0] beatCntNext;
    logic        cpuAct;
    logic        extGnt;
    logic        cpuStall;

    assign cpuAct = bus.cpu_rd | bus.cpu_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CPU_OWN;
            waitCnt <= '0;
            beatCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= waitCntNext;
            beatCnt <= beatCntNext;
        end
    end

    // CPU wins by default; a blocked external master escalates to a bounded forced burst.
    always_comb begin
        nextState   = state;
        waitCntNext = waitCnt;
        beatCntNext = beatCnt;
        extGnt      = 1'b0;
        cpuStall    = 1'b0;
        case (state)
            CPU_OWN: begin
                if (bus.ext_req && !cpuAct) begin
                    extGnt      = 1'b1;
                    waitCntNext = '0;
                end else if (bus.ext_req && cpuAct) begin
                    if (waitCnt == WAIT_W'(MAX_WAIT - 1)) begin
                        nextState   = EXT_OWN;
                        waitCntNext = '0;
                    end else begin
                        waitCntNext = waitCnt + 1'b1;
                    end
                end else begin
                    waitCntNext = '0;
                end
            end
            EXT_OWN: begin
                cpuStall    = cpuAct;
                waitCntNext = '0;
                if (bus.ext_req) begin
                    extGnt = 1'b1;
                    if (beatCnt == BEAT_W'(BURST_LEN - 1)) begin
                        nextState   = CPU_OWN;
                        beatCntNext = '0;
                    end else begin
                        beatCntNext = beatCnt + 1'b1;
                    end
                end else begin
                    nextState   = CPU_OWN;
                    beatCntNext = '0;
                end
            end
            default: begin
                nextState   = CPU_OWN;
                waitCntNext = '0;
                beatCntNext = '0;
            end
        endcase
    end

    // A stalled CPU must not touch memory, or its access would repeat on replay.
    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
        if (extGnt) begin
            bus.mem_rd    = !bus.ext_wr;
            bus.mem_wr    = bus.ext_wr;
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
        end else if (!cpuStall) begin
            bus.mem_rd = bus.cpu_rd;
            bus.mem_wr = bus.cpu_wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ext_rdata  <= '0;
            bus.ext_rvalid <= 1'b0;
        end else begin
            bus.ext_rvalid <= extGnt && !bus.ext_wr;
            if (extGnt && !bus.ext_wr)
                bus.ext_rdata <= bus.mem_rdata;
        end
    end

    assign bus.ext_gnt   = extGnt;
    assign bus.cpu_stall = cpuStall;
    assign bus.cpu_rdata = bus.mem_rdata;

`ifdef DMEM_ARB_PERF_EN
    dmem_arb_perf_cnt stallCounter (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .en    (cpuStall),
        .count (perf_stall_cnt)
    );

    dmem_arb_perf_cnt extCounter (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .en    (extGnt),
        .count (perf_ext_cnt)
    );
`endif

endmodule
